dual_skid_stage: RTL

Flow-controlled dual-operand pipeline stage carrying an M-bit and an N-bit word per beat with a valid/ready handshake on both sides. It takes the place of the plain enable-only dual register wherever a downstream stage must apply backpressure, e.g. between operand fetch and execute. A one-entry skid buffer keeps full throughput while making `in_ready` a registered signal, so there is no combinational ready path from output to input. A synchronous flush discards in-flight operands on branch or exception.

---
 rtl/dual_skid_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/dual_skid_stage.sv
// dual_skid_stage: valid/ready pipeline stage carrying two operand words per
// beat. A one-entry skid register absorbs the beat that arrives in the cycle
// downstream stalls, so in_ready depends only on registered state.
module dual_skid_stage #(
  parameter int unsigned M = 32,
  parameter int unsigned N = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] d1,
  input  logic [N-1:0] d2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] q1,
  output logic [N-1:0] q2
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q;
  logic [M-1:0]   main1_q;
  logic [N-1:0]   main2_q;
  logic [M-1:0]   skid1_q;
  logic [N-1:0]   skid2_q;
  logic           in_xfer;
  logic           out_xfer;

  // Handshake flags are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
    q1        = main1_q;
    q2        = main2_q;
  end

  // Occupancy FSM and data movement; flush empties the stage but leaves data untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      main1_q <= '0;
      main2_q <= '0;
      skid1_q <= '0;
      skid2_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main1_q <= d1;
            main2_q <= d2;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main1_q <= d1;
            main2_q <= d2;
          end else if (in_xfer) begin
            skid1_q <= d1;
            skid2_q <= d2;
            state_q <= FULL;
          end else if (out_xfer) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main1_q <= skid1_q;
            main2_q <= skid2_q;
            state_q <= BUSY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
